// File: rtl/booth_mac_accumulator_pkg.sv
// Shared types for the Booth MAC accumulator: FSM state encoding.
package booth_mac_accumulator_pkg;

  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StDone  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/booth_mac_accumulator_sat_adder.sv
// Combinational signed adder that clamps to the Acc_Width max/min on overflow.
module sat_adder #(
  parameter int unsigned Acc_Width = 8
) (
  input  logic [Acc_Width-1:0] a,
  input  logic [Acc_Width-1:0] b,
  output logic [Acc_Width-1:0] sum,
  output logic                 sat
);

  localparam logic [Acc_Width-1:0] MaxVal = {1'b0, {(Acc_Width-1){1'b1}}};
  localparam logic [Acc_Width-1:0] MinVal = {1'b1, {(Acc_Width-1){1'b0}}};

  logic [Acc_Width-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign the result does not.
    sat = (a[Acc_Width-1] == b[Acc_Width-1]) && (raw[Acc_Width-1] != a[Acc_Width-1]);
    sum = raw;
    if (sat) begin
      sum = a[Acc_Width-1] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Accumulates Num_Terms signed products per result with saturation, a one-entry
// pending buffer and a valid/ready output handshake.
module booth_mac_accumulator
  import booth_mac_accumulator_pkg::*;
#(
  parameter int unsigned Data_Width     = 3,
  parameter int unsigned Num_Terms      = 4,
  parameter int unsigned Acc_Width      = 2 * Data_Width + $clog2(Num_Terms),
  parameter int unsigned Term_Cnt_Width = $clog2(Num_Terms + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Multip_Finsh,
  input  logic [2*Data_Width-1:0]   Multiplication_Out,
  input  logic                      Clear,
  input  logic                      Acc_Ready,
  output logic                      Acc_Valid,
  output logic [Acc_Width-1:0]      Acc_Out,
  output logic [Term_Cnt_Width-1:0] Term_Count,
  output logic                      Sat_Flag,
  output logic                      Lost_Flag
);

  localparam logic [Term_Cnt_Width-1:0] LastCnt = Term_Cnt_Width'(Num_Terms);
  localparam logic [Term_Cnt_Width-1:0] OneCnt  = Term_Cnt_Width'(1);

  acc_state_e                state_q, state_d;
  logic                      finish_d_q;
  logic [Acc_Width-1:0]      acc_q, acc_d;
  logic [Term_Cnt_Width-1:0] cnt_q, cnt_d;
  logic                      sat_q, sat_d;
  logic                      lost_q, lost_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [2*Data_Width-1:0]   pend_q, pend_d;

  logic                 prod_event;
  logic [Acc_Width-1:0] p_ext, pend_ext, add_sum;
  logic                 add_sat;

  assign prod_event = Multip_Finsh & ~finish_d_q;
  assign p_ext      = Acc_Width'($signed(Multiplication_Out));
  assign pend_ext   = Acc_Width'($signed(pend_q));

  sat_adder #(
    .Acc_Width(Acc_Width)
  ) u_sat_adder (
    .a  (acc_q),
    .b  (p_ext),
    .sum(add_sum),
    .sat(add_sat)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    lost_d     = lost_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (Clear) begin
      state_d    = StAccum;
      acc_d      = '0;
      cnt_d      = '0;
      sat_d      = 1'b0;
      lost_d     = 1'b0;
      pend_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (prod_event) begin
            acc_d = add_sum;
            cnt_d = cnt_q + OneCnt;
            sat_d = sat_q | add_sat;
            if (cnt_d == LastCnt) state_d = StDone;
          end
        end
        StDone: begin
          if (Acc_Ready) begin
            state_d = StAccum;
            sat_d   = 1'b0;
            if (pend_vld_q) begin
              acc_d      = pend_ext;
              cnt_d      = OneCnt;
              pend_vld_d = prod_event;
              pend_d     = Multiplication_Out;
            end else if (prod_event) begin
              acc_d = p_ext;
              cnt_d = OneCnt;
            end else begin
              acc_d = '0;
              cnt_d = '0;
            end
            // A single-term result is complete as soon as it is loaded.
            if (cnt_d == LastCnt) state_d = StDone;
          end else if (prod_event) begin
            if (pend_vld_q) begin
              lost_d = 1'b1;
            end else begin
              pend_vld_d = 1'b1;
              pend_d     = Multiplication_Out;
            end
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccum;
      finish_d_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      lost_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      finish_d_q <= Multip_Finsh;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      lost_q     <= lost_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign Acc_Valid  = (state_q == StDone);
  assign Acc_Out    = acc_q;
  assign Term_Count = cnt_q;
  assign Sat_Flag   = sat_q;
  assign Lost_Flag  = lost_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: default 8-bit accumulator and a 6-bit
// instance to exercise saturation.
module tb_booth_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       fin, clr, rdy;
  logic [5:0] prod;
  logic       valid, sat, lost;
  logic [7:0] acc;
  logic [2:0] cnt;

  logic       fin6, clr6, rdy6;
  logic [5:0] prod6;
  logic       valid6, sat6, lost6;
  logic [5:0] acc6;
  logic [2:0] cnt6;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator u_dut (
    .clk               (clk),
    .rst               (rst),
    .Multip_Finsh      (fin),
    .Multiplication_Out(prod),
    .Clear             (clr),
    .Acc_Ready         (rdy),
    .Acc_Valid         (valid),
    .Acc_Out           (acc),
    .Term_Count        (cnt),
    .Sat_Flag          (sat),
    .Lost_Flag         (lost)
  );

  booth_mac_accumulator #(
    .Data_Width(3),
    .Num_Terms (4),
    .Acc_Width (6)
  ) u_dut6 (
    .clk               (clk),
    .rst               (rst),
    .Multip_Finsh      (fin6),
    .Multiplication_Out(prod6),
    .Clear             (clr6),
    .Acc_Ready         (rdy6),
    .Acc_Valid         (valid6),
    .Acc_Out           (acc6),
    .Term_Count        (cnt6),
    .Sat_Flag          (sat6),
    .Lost_Flag         (lost6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Product on first edge, finish low on second edge.
  task automatic send(input logic [5:0] v);
    fin  = 1'b1;
    prod = v;
    tick();
    fin = 1'b0;
    tick();
  endtask

  task automatic send6(input logic [5:0] v);
    fin6  = 1'b1;
    prod6 = v;
    tick();
    fin6 = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    compared++;
    if ({valid, acc, cnt, sat, lost} !== 14'b0) begin
      mismatched++;
      $display("FAIL reset: got valid=%b acc=%h cnt=%0d sat=%b lost=%b, need all 0",
               valid, acc, cnt, sat, lost);
    end
  endtask

  task automatic test_basic();
    send(6'd6);
    compared++;
    if (acc !== 8'h06 || cnt !== 3'd1) begin
      mismatched++;
      $display("FAIL basic_first: got acc=%h cnt=%0d, need 06/1", acc, cnt);
    end
    send(6'(-3));
    send(6'd16);
    compared++;
    if (valid !== 1'b0 || acc !== 8'h13) begin
      mismatched++;
      $display("FAIL basic_three: got valid=%b acc=%h, need 0/13", valid, acc);
    end
    fin  = 1'b1;
    prod = 6'(-8);
    tick();
    fin = 1'b0;
    compared++;
    if (valid !== 1'b1 || acc !== 8'h0B || cnt !== 3'd4 || sat !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_done: got valid=%b acc=%h cnt=%0d sat=%b, need 1/0B/4/0",
               valid, acc, cnt, sat);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    compared++;
    if (valid !== 1'b0 || acc !== 8'h00 || cnt !== 3'd0) begin
      mismatched++;
      $display("FAIL basic_handshake: got valid=%b acc=%h cnt=%0d, need 0/00/0",
               valid, acc, cnt);
    end
  endtask

  task automatic test_held_finish();
    fin  = 1'b1;
    prod = 6'd5;
    repeat (10) tick();
    compared++;
    if (cnt !== 3'd1 || acc !== 8'h05) begin
      mismatched++;
      $display("FAIL held_once: got cnt=%0d acc=%h, need 1/05", cnt, acc);
    end
    fin = 1'b0;
    tick();
    send(6'd5);
    compared++;
    if (cnt !== 3'd2 || acc !== 8'h0A) begin
      mismatched++;
      $display("FAIL held_second_edge: got cnt=%0d acc=%h, need 2/0A", cnt, acc);
    end
    do_clear();
  endtask

  task automatic test_pending_lost();
    repeat (4) send(6'(-12));
    compared++;
    if (valid !== 1'b1 || acc !== 8'hD0) begin
      mismatched++;
      $display("FAIL pend_sum: got valid=%b acc=%h, need 1/D0", valid, acc);
    end
    send(6'd7);
    compared++;
    if (acc !== 8'hD0 || lost !== 1'b0 || cnt !== 3'd4) begin
      mismatched++;
      $display("FAIL pend_store: got acc=%h lost=%b cnt=%0d, need D0/0/4", acc, lost, cnt);
    end
    send(6'd3);
    compared++;
    if (acc !== 8'hD0 || lost !== 1'b1 || valid !== 1'b1) begin
      mismatched++;
      $display("FAIL pend_lost: got acc=%h lost=%b valid=%b, need D0/1/1", acc, lost, valid);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    compared++;
    if (valid !== 1'b0 || acc !== 8'h07 || cnt !== 3'd1 || lost !== 1'b1) begin
      mismatched++;
      $display("FAIL pend_drain: got valid=%b acc=%h cnt=%0d lost=%b, need 0/07/1/1",
               valid, acc, cnt, lost);
    end
    do_clear();
    compared++;
    if (lost !== 1'b0 || acc !== 8'h00 || cnt !== 3'd0) begin
      mismatched++;
      $display("FAIL pend_clear: got lost=%b acc=%h cnt=%0d, need 0/00/0", lost, acc, cnt);
    end
  endtask

  task automatic test_saturate();
    send6(6'd16);
    compared++;
    if (acc6 !== 6'd16 || sat6 !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_first: got acc=%0d sat=%b, need 16/0", acc6, sat6);
    end
    send6(6'd16);
    compared++;
    if (acc6 !== 6'd31 || sat6 !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_clamp: got acc=%0d sat=%b, need 31/1", acc6, sat6);
    end
    send6(6'd16);
    send6(6'd16);
    compared++;
    if (acc6 !== 6'd31 || sat6 !== 1'b1 || valid6 !== 1'b1 || cnt6 !== 3'd4) begin
      mismatched++;
      $display("FAIL sat_done: got acc=%0d sat=%b valid=%b cnt=%0d, need 31/1/1/4",
               acc6, sat6, valid6, cnt6);
    end
    rdy6 = 1'b1;
    tick();
    rdy6 = 1'b0;
    compared++;
    if (sat6 !== 1'b0 || acc6 !== 6'd0 || valid6 !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_handshake: got sat=%b acc=%0d valid=%b, need 0/0/0",
               sat6, acc6, valid6);
    end
  endtask

  task automatic test_clear_event();
    send(6'd4);
    send(6'd2);
    fin  = 1'b1;
    prod = 6'd9;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    compared++;
    if (acc !== 8'h00 || cnt !== 3'd0 || lost !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_event: got acc=%h cnt=%0d lost=%b, need 00/0/0", acc, cnt, lost);
    end
    tick();
    tick();
    compared++;
    if (cnt !== 3'd0 || acc !== 8'h00) begin
      mismatched++;
      $display("FAIL clear_held: got cnt=%0d acc=%h, need 0/00", cnt, acc);
    end
    fin = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    send(6'd4);
    send(6'd2);
    fin  = 1'b1;
    prod = 6'd5;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if ({valid, acc, cnt, sat, lost} !== 14'b0) begin
      mismatched++;
      $display("FAIL midrst_zero: got valid=%b acc=%h cnt=%0d sat=%b lost=%b, need all 0",
               valid, acc, cnt, sat, lost);
    end
    tick();
    fin = 1'b0;
    compared++;
    if (cnt !== 3'd1 || acc !== 8'h05) begin
      mismatched++;
      $display("FAIL midrst_recount: got cnt=%0d acc=%h, need 1/05", cnt, acc);
    end
  endtask

  initial begin
    rst   = 1'b1;
    fin   = 1'b0;
    clr   = 1'b0;
    rdy   = 1'b0;
    prod  = '0;
    fin6  = 1'b0;
    clr6  = 1'b0;
    rdy6  = 1'b0;
    prod6 = '0;
    #1;
    test_reset();
    test_basic();
    test_held_finish();
    test_pending_lost();
    test_saturate();
    test_clear_event();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth_mac_accumulator.md
Name: booth_mac_accumulator

Overview:
Downstream stage of the Booth sequential multiplier. It consumes the signed product on each rising edge of the multiplier's finish flag and accumulates Num_Terms products into a saturating signed sum (dot-product / MAC). It presents the sum to the next stage with a valid/ready handshake. A one-entry pending buffer absorbs a product that arrives while the result is stalled.

Parameters:
Data_Width, 3, operand width of upstream multiplier; product width is 2*Data_Width
Num_Terms, 4, products per accumulated result (>=1)
Acc_Width, 2*Data_Width+$clog2(Num_Terms), accumulator width; must be >= 2*Data_Width
Term_Cnt_Width, $clog2(Num_Terms+1), width of term counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
Multip_Finsh  input  1  upstream finish flag, level; may stay high many cycles
Multiplication_Out  input  2*Data_Width  signed product, valid while Multip_Finsh high
Clear  input  1  synchronous flush of accumulation state
Acc_Ready  input  1  downstream ready
Acc_Valid  output  1  result valid
Acc_Out  output  Acc_Width  signed accumulated result
Term_Count  output  Term_Cnt_Width  terms accumulated so far
Sat_Flag  output  1  current Acc_Out was clamped at least once
Lost_Flag  output  1  sticky: product dropped, pending buffer full

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: Acc_Out=0, Acc_Valid=0, Term_Count=0, Sat_Flag=0, Lost_Flag=0, pending empty, finish_d=0, state ACCUM.
- Product event: Multip_Finsh & ~finish_d, where finish_d is Multip_Finsh registered every cycle. A level held high counts once. A high level right after reset counts.
- Product is sign-extended to Acc_Width. The adder saturates to the max or min of Acc_Width: on overflow it clamps and sets Sat_Flag.
- FSM ACCUM:
  - On an event: Acc_Out <= sat(Acc_Out + p) and Term_Count++. The update is visible the cycle after the event.
  - When Term_Count reaches Num_Terms, go to DONE. Acc_Valid=1 from the next cycle, one cycle after the last term.
- FSM DONE:
  - Acc_Out, Term_Count and Sat_Flag are held stable while Acc_Valid=1 and Acc_Ready=0.
  - An event with pending empty stores p in pending.
  - An event with pending full drops p and sets Lost_Flag.
- Handshake (Acc_Valid & Acc_Ready at an edge): go to ACCUM and clear Sat_Flag. Acc_Out and Term_Count are then set as follows:
  - Pending empty, no event: Acc_Out=0, Term_Count=0.
  - Pending full: Acc_Out=sext(pending), Term_Count=1, pending cleared. A same-cycle event loads pending with the new p.
  - Pending empty, same-cycle event: Acc_Out=sext(p), Term_Count=1.
- Num_Terms=1: each accepted term goes straight to DONE.
- Clear (priority below rst, above all else): Acc_Out=0, Term_Count=0, Acc_Valid=0, Sat_Flag=0, Lost_Flag=0, pending empty, state ACCUM. A coincident event is discarded. finish_d still updates, so a held finish is not recounted.
- rst mid-operation: same outputs as Clear, plus finish_d=0.
- No combinational path from Multip_Finsh or Acc_Ready to any output.

Decomposition:
- Shared package/header: FSM state encodings (ACCUM, DONE) and the sign-extend/saturate-limit constants derived from Acc_Width.
- One sub-module, sat_adder: combinational, parameter Acc_Width, inputs a and b, outputs sum and sat. Clamps on sign overflow.
- Edge detect, pending buffer, counter and FSM stay in the top.

Test Plan:
1. Defaults; four finish pulses with products 6, -3, 16, -8; Acc_Ready=1 from cycle after valid -> Acc_Out=8'h0B (11), Acc_Valid high exactly 1 cycle after 4th event, Term_Count=4, Sat_Flag=0; after handshake Acc_Out=0, Term_Count=0.
2. Multip_Finsh held high 10 cycles with product 5 -> Term_Count=1, Acc_Out=5; a second rising edge is required to reach Term_Count=2.
3. Four products -12 -> Acc_Out=8'hD0 (-48). Hold Acc_Ready=0; send product 7 -> pending. Send product 3 -> Lost_Flag=1 and Acc_Out stays 8'hD0. Pulse Acc_Ready -> next cycle Acc_Valid=0, Acc_Out=7, Term_Count=1, Lost_Flag still 1.
4. Acc_Width=6; four products 16 -> sums 16, then 31 clamped for the rest; Acc_Out=31, Sat_Flag=1 with Acc_Valid; Sat_Flag=0 after handshake.
5. Two terms (4, 2) accumulated, then Clear coincident with product event 9 -> Acc_Out=0, Term_Count=0, Lost_Flag=0; 9 not counted while finish stays high.
6. Two terms accumulated, then rst for 1 cycle -> all outputs 0 next cycle; finish still high after reset counts as a new event (Term_Count=1).
